// File: rtl/opcodes.sv
// Shared ISA types for the memory pipeline: opcodes, instruction word, register type and helpers.
package opcodes;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned BE_W      = XLEN / 8;
    localparam int unsigned ERR_CNT_W = 3;

    typedef logic [XLEN-1:0] register_t;

    typedef enum logic [5:0] {
        OP_NOP = 6'h00,
        OP_ADD = 6'h01,
        OP_SUB = 6'h02,
        OP_AND = 6'h03,
        OP_OR  = 6'h04,
        M_LB   = 6'h10,
        M_LH   = 6'h11,
        M_LW   = 6'h12,
        M_SB   = 6'h18,
        M_SH   = 6'h19,
        M_SW   = 6'h1a
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [10:0] imm;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    function automatic instruction_t encode_rtype(opcode_t op, logic [4:0] rd,
                                                  logic [4:0] rs1, logic [4:0] rs2);
        return '{opcode: op, rd: rd, rs1: rs1, rs2: rs2, imm: '0};
    endfunction

    function automatic string print_opcode(opcode_t op);
        return op.name();
    endfunction

    function automatic logic is_mem_op(opcode_t op);
        return op inside {M_LB, M_LH, M_LW, M_SB, M_SH, M_SW};
    endfunction

    function automatic logic is_store(opcode_t op);
        return op inside {M_SB, M_SH, M_SW};
    endfunction

    // Halfword accesses drop bit 0, word accesses drop bits 1:0.
    function automatic register_t align_addr(opcode_t op, register_t ea);
        case (op)
            M_LH, M_SH: return {ea[XLEN-1:1], 1'b0};
            M_LW, M_SW: return {ea[XLEN-1:2], 2'b00};
            default:    return ea;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane select plus sign extension for loads.
module mem_lane_align
    import opcodes::*;
(
    input  opcode_t         op,
    input  logic [1:0]      lane,
    input  register_t       store_data,
    input  register_t       read_data,
    output logic [BE_W-1:0] byte_en_c,
    output register_t       write_data_c,
    output register_t       load_data_c
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        byte_en_c    = '0;
        write_data_c = '0;
        load_data_c  = '0;
        rd_byte      = read_data[{lane, 3'b000} +: 8];
        rd_half      = lane[1] ? read_data[31:16] : read_data[15:0];
        case (op)
            M_SB: begin
                byte_en_c    = BE_W'(1) << lane;
                write_data_c = {4{store_data[7:0]}};
            end
            M_SH: begin
                byte_en_c    = lane[1] ? 4'b1100 : 4'b0011;
                write_data_c = {2{store_data[15:0]}};
            end
            M_SW: begin
                byte_en_c    = 4'b1111;
                write_data_c = store_data;
            end
            M_LB:    load_data_c = {{24{rd_byte[7]}}, rd_byte};
            M_LH:    load_data_c = {{16{rd_half[15]}}, rd_half};
            M_LW:    load_data_c = read_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/ssram.sv
// Word-organised synchronous-write memory with immediate acknowledge; 64 words.
module ssram
    import opcodes::*;
(
    input  logic            clk,
    input  logic [31:0]     address,
    input  logic            read_enable,
    output register_t       read_data,
    output logic            read_ack,
    input  logic            write_enable,
    input  logic [BE_W-1:0] write_byte_enable,
    input  register_t       write_data,
    output logic            write_ack
);

    localparam int unsigned DEPTH_W = 6;
    localparam int unsigned DEPTH   = 1 << DEPTH_W;

    register_t           mem [DEPTH];
    logic [DEPTH_W-1:0]  idx;
    logic                unused_addr;

    assign idx         = address[DEPTH_W+1:2];
    assign unused_addr = ^{address[31:DEPTH_W+2], address[1:0]};
    assign read_data   = mem[idx];
    assign read_ack    = read_enable;
    assign write_ack   = write_enable;

    always_ff @(posedge clk) begin
        if (write_enable) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (write_byte_enable[b]) mem[idx][8*b +: 8] <= write_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_ctrl.sv
// Load/store unit: one outstanding access, IDLE -> ACCESS (wait ack) -> DONE (result pulse).
module memory_ctrl
    import opcodes::*;
#(
    parameter int random_errors = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  instruction_t    instr,
    input  register_t       op1,
    input  register_t       op2,
    input  register_t       op3,
    input  logic            enable,
    output register_t       result,
    output logic            result_valid,
    output logic [31:0]     address,
    output logic            read_enable,
    input  logic [31:0]     read_data,
    input  logic            read_ack,
    output logic            write_enable,
    output logic [BE_W-1:0] write_byte_enable,
    output logic [31:0]     write_data,
    input  logic            write_ack
);

    mem_state_t             state, state_d;
    opcode_t                op_q, op_d;
    register_t              load_q, load_d;
    logic [ERR_CNT_W-1:0]   err_cnt, err_cnt_d;
    register_t              result_d, address_d, write_data_d;
    logic                   valid_d, read_en_d, write_en_d;
    logic [BE_W-1:0]        wbe_d;

    register_t              ea_c, addr_c, load_val;
    logic                   start_c, ack_c;
    opcode_t                lane_op;
    logic [1:0]             lane;
    logic [BE_W-1:0]        lane_be;
    register_t              lane_wdata, lane_load;
    logic                   unused_instr;

    assign unused_instr = ^{instr.rd, instr.rs1, instr.rs2, instr.imm};
    assign ea_c         = op1 + op2;
    assign addr_c       = align_addr(instr.opcode, ea_c);
    assign start_c      = enable && is_mem_op(instr.opcode);
    assign ack_c        = (read_enable && read_ack) || (write_enable && write_ack);

    // Stores are steered from live inputs at launch; loads from the captured access at ack.
    assign lane_op = (state == IDLE) ? instr.opcode : op_q;
    assign lane    = (state == IDLE) ? addr_c[1:0]  : address[1:0];

    mem_lane_align u_align (
        .op           (lane_op),
        .lane         (lane),
        .store_data   (op3),
        .read_data    (read_data),
        .byte_en_c    (lane_be),
        .write_data_c (lane_wdata),
        .load_data_c  (lane_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            op_q              <= OP_NOP;
            load_q            <= '0;
            err_cnt           <= '0;
            result            <= '0;
            result_valid      <= 1'b0;
            address           <= '0;
            read_enable       <= 1'b0;
            write_enable      <= 1'b0;
            write_byte_enable <= '0;
            write_data        <= '0;
        end else begin
            state             <= state_d;
            op_q              <= op_d;
            load_q            <= load_d;
            err_cnt           <= err_cnt_d;
            result            <= result_d;
            result_valid      <= valid_d;
            address           <= address_d;
            read_enable       <= read_en_d;
            write_enable      <= write_en_d;
            write_byte_enable <= wbe_d;
            write_data        <= write_data_d;
        end
    end

    always_comb begin
        state_d      = state;
        op_d         = op_q;
        load_d       = load_q;
        err_cnt_d    = err_cnt;
        result_d     = result;
        valid_d      = 1'b0;
        address_d    = address;
        read_en_d    = read_enable;
        write_en_d   = write_enable;
        wbe_d        = write_byte_enable;
        write_data_d = write_data;
        load_val     = lane_load;
        if (random_errors != 0 && err_cnt == '1) load_val[0] = ~load_val[0];

        case (state)
            IDLE: begin
                if (start_c) begin
                    state_d   = ACCESS;
                    op_d      = instr.opcode;
                    address_d = addr_c;
                    if (is_store(instr.opcode)) begin
                        write_en_d   = 1'b1;
                        wbe_d        = lane_be;
                        write_data_d = lane_wdata;
                    end else begin
                        read_en_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (ack_c) begin
                    state_d    = DONE;
                    valid_d    = 1'b1;
                    read_en_d  = 1'b0;
                    write_en_d = 1'b0;
                    wbe_d      = '0;
                    if (read_enable) begin
                        result_d  = load_val;
                        load_d    = load_val;
                        err_cnt_d = err_cnt + ERR_CNT_W'(1);
                    end else begin
                        result_d = '0;
                    end
                end
            end
            DONE: begin
                // Store pulses show zero; afterwards result reverts to the last load.
                state_d  = IDLE;
                result_d = load_q;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_ctrl.sv
// Scoreboard bench for memory_ctrl with ssram; a second instance exercises fault injection.
module tb_memory_ctrl;
    import opcodes::*;

    typedef struct {
        string     tag;
        register_t res;
        register_t addr;
        logic      is_st;
        logic [3:0] be;
        register_t wdata;
        int        start;
        int        lat;
    } sb_item_t;

    logic         clk = 1'b0;
    logic         rst;
    instruction_t instr;
    register_t    op1, op2, op3;
    logic         enable;
    logic         ack_en;

    register_t    result, e_result;
    logic         result_valid, e_result_valid;
    logic [31:0]  address, e_address;
    logic         read_enable, e_read_enable, write_enable, e_write_enable;
    logic [3:0]   write_byte_enable, e_write_byte_enable;
    logic [31:0]  write_data, e_write_data;
    register_t    ram_rdata, e_ram_rdata;
    logic         ram_rack, ram_wack, e_ram_rack, e_ram_wack;

    sb_item_t     sb_q[$];
    register_t    err_q[$];
    sb_item_t     mon_item;
    register_t    err_exp;
    register_t    err_bits;
    int           err_mism;
    logic         err_track;
    int           n_checks, n_fail, valid_cnt, cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_ctrl #(.random_errors(0)) dut (
        .clk(clk), .rst(rst), .instr(instr), .op1(op1), .op2(op2), .op3(op3), .enable(enable),
        .result(result), .result_valid(result_valid), .address(address),
        .read_enable(read_enable), .read_data(ram_rdata), .read_ack(ram_rack & ack_en),
        .write_enable(write_enable), .write_byte_enable(write_byte_enable),
        .write_data(write_data), .write_ack(ram_wack & ack_en)
    );

    ssram u_ram (
        .clk(clk), .address(address), .read_enable(read_enable), .read_data(ram_rdata),
        .read_ack(ram_rack), .write_enable(write_enable), .write_byte_enable(write_byte_enable),
        .write_data(write_data), .write_ack(ram_wack)
    );

    memory_ctrl #(.random_errors(1)) dut_err (
        .clk(clk), .rst(rst), .instr(instr), .op1(op1), .op2(op2), .op3(op3), .enable(enable),
        .result(e_result), .result_valid(e_result_valid), .address(e_address),
        .read_enable(e_read_enable), .read_data(e_ram_rdata), .read_ack(e_ram_rack & ack_en),
        .write_enable(e_write_enable), .write_byte_enable(e_write_byte_enable),
        .write_data(e_write_data), .write_ack(e_ram_wack & ack_en)
    );

    ssram u_ram_err (
        .clk(clk), .address(e_address), .read_enable(e_read_enable), .read_data(e_ram_rdata),
        .read_ack(e_ram_rack), .write_enable(e_write_enable),
        .write_byte_enable(e_write_byte_enable), .write_data(e_write_data),
        .write_ack(e_ram_wack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Main DUT monitor: result pulses pop the scoreboard; strobes are checked against its head.
    always @(negedge clk) begin
        if (rst) begin
            if (result_valid) begin
                valid_cnt++;
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_valid", 32'(result_valid), 32'd0);
                end else begin
                    mon_item = sb_q.pop_front();
                    check_eq({mon_item.tag, "_result"}, result, mon_item.res);
                    check_eq({mon_item.tag, "_latency"}, 32'(cyc - mon_item.start + 1),
                             32'(mon_item.lat));
                end
            end
            if ((read_enable || write_enable) && sb_q.size() != 0) begin
                check_eq({sb_q[0].tag, "_addr"}, address, sb_q[0].addr);
                check_eq({sb_q[0].tag, "_we"}, 32'(write_enable), 32'(sb_q[0].is_st));
                if (write_enable) begin
                    check_eq({sb_q[0].tag, "_be"}, 32'(write_byte_enable), 32'(sb_q[0].be));
                    check_eq({sb_q[0].tag, "_wdata"}, write_data, sb_q[0].wdata);
                end
            end
            if (!read_enable && !write_enable)
                check_eq("idle_byte_en", 32'(write_byte_enable), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (rst && e_result_valid && err_q.size() != 0) begin
            err_exp = err_q.pop_front();
            if (e_result !== err_exp) begin
                err_mism++;
                err_bits = err_bits | (e_result ^ err_exp);
            end
        end
    end

    task automatic start_op(input opcode_t op, input register_t base, input register_t off,
                            input register_t data, input register_t exp_res,
                            input register_t exp_addr, input logic [3:0] exp_be,
                            input register_t exp_wdata, input int lat, input string tag);
        sb_item_t it;
        it = '{tag, exp_res, exp_addr, is_store(op), exp_be, exp_wdata, cyc + 1, lat};
        instr  = encode_rtype(op, 5'd1, 5'd2, 5'd3);
        op1    = base;
        op2    = off;
        op3    = data;
        enable = 1'b1;
        sb_q.push_back(it);
        if (err_track) err_q.push_back(exp_res);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        #1;
    endtask

    task automatic do_op(input opcode_t op, input register_t base, input register_t off,
                         input register_t data, input register_t exp_res,
                         input register_t exp_addr, input logic [3:0] exp_be,
                         input register_t exp_wdata, input string tag);
        start_op(op, base, off, data, exp_res, exp_addr, exp_be, exp_wdata, 2, tag);
        @(posedge clk);
        #1 enable = 1'b0;
        wait_drain(40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int vb;
        register_t d;
        n_checks = 0; n_fail = 0; valid_cnt = 0; cyc = 0;
        err_mism = 0; err_bits = '0; err_track = 1'b0;
        rst = 1'b0; enable = 1'b0; ack_en = 1'b1;
        instr = encode_rtype(OP_NOP, 5'd0, 5'd0, 5'd0);
        op1 = '0; op2 = '0; op3 = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_address", address, 32'd0);
        check_eq("rst_strobes", 32'({read_enable, write_enable}), 32'd0);
        check_eq("rst_be", 32'(write_byte_enable), 32'd0);
        check_eq("rst_wdata", write_data, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Word test: base+offset wraps modulo 2^32 onto 4*i.
        err_track = 1'b1;
        for (int i = 0; i < 16; i++)
            do_op(M_SW, 32'(4*i + 100), 32'hFFFF_FF9C, 32'(i), 32'd0, 32'(4*i), 4'hF, 32'(i), "sw");
        for (int i = 0; i < 16; i++)
            do_op(M_LW, 32'(4*i + 100), 32'hFFFF_FF9C, 32'd0, 32'(i), 32'(4*i), 4'h0, 32'd0, "lw");
        err_track = 1'b0;
        check_eq("err_inject_count", 32'(err_mism), 32'd2);
        check_eq("err_inject_bits", err_bits, 32'd1);
        do_op(M_LW, 32'd13, 32'd0, 32'd0, 32'd3, 32'd12, 4'h0, 32'd0, "lw_misaligned");

        for (int i = 0; i < 32; i++) begin
            d = 32'(i);
            do_op(M_SH, 32'(2*i), 32'd0, 32'hBEEF_0000 | d, 32'd0, 32'(2*i),
                  (i % 2 == 0) ? 4'b0011 : 4'b1100, {d[15:0], d[15:0]}, "sh");
        end
        for (int i = 0; i < 32; i++)
            do_op(M_LH, 32'(2*i), 32'd0, 32'd0, 32'(i), 32'(2*i), 4'h0, 32'd0, "lh");

        for (int i = 0; i < 64; i++) begin
            d = 32'(i);
            do_op(M_SB, 32'd0, 32'(i), d, 32'd0, 32'(i), 4'(4'b0001 << (i % 4)),
                  {4{d[7:0]}}, "sb");
        end
        for (int i = 0; i < 64; i++)
            do_op(M_LB, 32'd0, 32'(i), 32'd0, 32'(i), 32'(i), 4'h0, 32'd0, "lb");

        do_op(M_SB, 32'd5, 32'd0, 32'h0000_0080, 32'd0, 32'd5, 4'b0010, 32'h8080_8080, "sb_neg");
        do_op(M_LB, 32'd5, 32'd0, 32'd0, 32'hFFFF_FF80, 32'd5, 4'h0, 32'd0, "lb_neg");
        do_op(M_SH, 32'd3, 32'hFFFF_FFFF, 32'hABCD_8001, 32'd0, 32'd2, 4'b1100, 32'h8001_8001,
              "sh_neg");
        check_eq("result_hold_after_store", result, 32'hFFFF_FF80);
        do_op(M_LH, 32'd2, 32'd0, 32'd0, 32'hFFFF_8001, 32'd2, 4'h0, 32'd0, "lh_neg");

        // Handshake: ack withheld for three access cycles, with a stray enable in between.
        vb = valid_cnt;
        ack_en = 1'b0;
        start_op(M_LW, 32'd8, 32'd0, 32'd0, 32'h0B0A_0908, 32'd8, 4'h0, 32'd0, 5, "hs_lw");
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        check_eq("hs_rd_en_1", 32'(read_enable), 32'd1);
        @(posedge clk);
        #1;
        instr = encode_rtype(M_SW, 5'd0, 5'd0, 5'd0);
        op1 = '0; op2 = '0; op3 = 32'hDEAD_BEEF; enable = 1'b1;
        @(negedge clk);
        check_eq("hs_rd_en_2", 32'(read_enable), 32'd1);
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        check_eq("hs_rd_en_3", 32'(read_enable), 32'd1);
        @(posedge clk);
        #1 ack_en = 1'b1;
        wait_drain(20);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hs_single_valid", 32'(valid_cnt - vb), 32'd1);
        do_op(M_LW, 32'd0, 32'd0, 32'd0, 32'h8001_0100, 32'd0, 4'h0, 32'd0, "hs_ignored_sw");

        vb = valid_cnt;
        instr = encode_rtype(OP_ADD, 5'd1, 5'd2, 5'd3);
        op1 = 32'd4; op2 = 32'd4; op3 = 32'd7; enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("nop_no_valid", 32'(valid_cnt - vb), 32'd0);

        // Reset in the middle of a store aborts it without a result pulse or memory write.
        ack_en = 1'b0;
        start_op(M_SW, 32'd8, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd8, 4'hF, 32'hFFFF_FFFF, 2, "rst_sw");
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("midrst_we", 32'(write_enable), 32'd0);
        check_eq("midrst_re", 32'(read_enable), 32'd0);
        check_eq("midrst_be", 32'(write_byte_enable), 32'd0);
        check_eq("midrst_result", result, 32'd0);
        check_eq("midrst_address", address, 32'd0);
        check_eq("midrst_wdata", write_data, 32'd0);
        sb_q.delete();
        vb = valid_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        ack_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("midrst_no_valid", 32'(valid_cnt - vb), 32'd0);
        do_op(M_LW, 32'd8, 32'd0, 32'd0, 32'h0B0A_0908, 32'd8, 4'h0, 32'd0, "post_rst_lw");
        do_op(M_SB, 32'd9, 32'd0, 32'h0000_00C3, 32'd0, 32'd9, 4'b0010, 32'hC3C3_C3C3,
              "post_rst_sb");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
